fp_alu_sequencer: RTL and testbench

Multi-cycle controller that accepts one ALU instruction at a time over a valid/ready handshake and sequences it across the two-entry working register pair, the 64-word memory and an external IEEE-754 add/multiply unit. It replaces free-running opcode decode with an explicit state machine, so every operation has a defined latency and a single `result_valid` pulse. The block sits between the instruction source and the datapath. It owns the working registers; memory and the FP unit are external.

---
 rtl/fp_alu_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_fp_alu_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_alu_sequencer.sv
// fp_alu_sequencer: multi-cycle sequencer for one ALU instruction at a time.
// Owns the r0/r1 working pair, drives the external 64-word memory and the
// external FP add/multiply unit, and emits one result_valid pulse per op.
//
// Optional feature macro: FP_SEQ_TIMEOUT_EN
//   defined   : WAIT_FP aborts after FP_TIMEOUT cycles, err goes sticky high.
//   undefined : WAIT_FP waits for fp_done forever, err is tied low.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | ready for a new instruction, fields latched on acceptance
// FP_ISSUE | one-cycle fp_start pulse
// WAIT_FP  | operands held stable until fp_done (or timeout)
// MEM_RD   | mem_re strobe
// MEM_WAIT | read data arrives, load result formed
// MEM_WR   | mem_we strobe with store data
// WB       | result_valid pulse, register writeback at the end of the cycle
module fp_alu_sequencer #(
    parameter int FP_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [3:0]  opcode,
    input  logic        sel,
    input  logic [5:0]  adr,
    input  logic [1:0]  bsel,
    input  logic [31:0] imm,
    output logic        mem_we,
    output logic        mem_re,
    output logic [5:0]  mem_adr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        fp_start,
    output logic        fp_op,
    output logic [31:0] fp_a,
    output logic [31:0] fp_b,
    input  logic        fp_done,
    input  logic [31:0] fp_result,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        busy,
    output logic        err,
    output logic [31:0] r0_q,
    output logic [31:0] r1_q
);

    typedef enum logic [2:0] {
        IDLE, FP_ISSUE, WAIT_FP, MEM_RD, MEM_WAIT, MEM_WR, WB
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  op_q;
    logic        sel_q;
    logic [5:0]  adr_q;
    logic [1:0]  bsel_q;
    logic [31:0] imm_q;
    logic [31:0] r0, r1, result_q;
    logic        wb_en_q;
    logic [31:0] rs_in, ro_in, rs_cur;
    logic        fp_timeout;

    // Register-only ops resolve at acceptance so WB is the very next cycle.
    function automatic logic [31:0] int_calc(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] rs,
                                             input logic [31:0] ro, input logic [31:0] im);
        case (op)
            4'h3:    return a & b;
            4'h4:    return a | b;
            4'h7:    return rs + im;
            4'hD:    return rs << ro[4:0];
            4'hF:    return 32'($signed(rs) >>> ro[4:0]);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] store_calc(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] rs,
                                               input logic [31:0] im, input logic [1:0] bs);
        logic [31:0] sh;
        sh = rs >> {bs, 3'b000};
        case (op)
            4'h5:    return {31'h0, a < b};
            4'h8:    return {31'h0, rs < im};
            4'h9:    return {24'h0, sh[7:0]};
            4'hC:    return {16'h0, rs[15:0]};
            4'hE:    return rs;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] load_calc(input logic [3:0] op, input logic [31:0] rs,
                                              input logic [31:0] rd, input logic [1:0] bs);
        case (op)
            4'hA: begin
                case (bs)
                    2'd0:    return {rs[31:8], rd[7:0]};
                    2'd1:    return {rs[31:16], rd[7:0], rs[7:0]};
                    2'd2:    return {rs[31:24], rd[7:0], rs[15:0]};
                    default: return {rd[7:0], rs[23:0]};
                endcase
            end
            4'hB:    return {rs[31:16], rd[15:0]};
            default: return rd;
        endcase
    endfunction

    function automatic logic writes_reg(input logic [3:0] op);
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'hA, 4'hB, 4'hD, 4'hF: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign rs_in  = sel   ? r1 : r0;
    assign ro_in  = sel   ? r0 : r1;
    assign rs_cur = sel_q ? r1 : r0;

    // Registers only change in WB, so live r0/r1 equal the values at acceptance.
    assign fp_a      = r0;
    assign fp_b      = (op_q == 4'h1) ? {~r1[31], r1[30:0]} : r1;
    assign fp_op     = (op_q == 4'h2);
    assign mem_adr   = adr_q;
    assign mem_wdata = store_calc(op_q, r0, r1, rs_cur, imm_q, bsel_q);
    assign result    = result_q;
    assign r0_q      = r0;
    assign r1_q      = r1;

`ifdef FP_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(FP_TIMEOUT);
    logic [CNT_W-1:0] fp_cnt;
    logic             err_q;

    // fp_done on the final cycle takes priority over the abort.
    assign fp_timeout = (state == WAIT_FP) && !fp_done
                        && (fp_cnt == CNT_W'(FP_TIMEOUT - 1));
    assign err = err_q;

    // Wait counter: held at zero outside WAIT_FP so every wait starts from 0.
    always_ff @(posedge clk) begin
        if (reset || state != WAIT_FP) fp_cnt <= '0;
        else                           fp_cnt <= fp_cnt + CNT_W'(1);
    end

    // Sticky abort flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)           err_q <= 1'b0;
        else if (fp_timeout) err_q <= 1'b1;
    end
`else
    assign fp_timeout = 1'b0;
    assign err        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        state_nxt    = state;
        instr_ready  = 1'b0;
        busy         = 1'b1;
        fp_start     = 1'b0;
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) begin
                    case (opcode)
                        4'h0, 4'h1, 4'h2:             state_nxt = FP_ISSUE;
                        4'h6, 4'hA, 4'hB:             state_nxt = MEM_RD;
                        4'h5, 4'h8, 4'h9, 4'hC, 4'hE: state_nxt = MEM_WR;
                        default:                      state_nxt = WB;
                    endcase
                end
            end
            FP_ISSUE: begin
                fp_start  = 1'b1;
                state_nxt = WAIT_FP;
            end
            WAIT_FP:  if (fp_done || fp_timeout) state_nxt = WB;
            MEM_RD: begin
                mem_re    = 1'b1;
                state_nxt = MEM_WAIT;
            end
            MEM_WAIT: state_nxt = WB;
            MEM_WR: begin
                mem_we    = 1'b1;
                state_nxt = WB;
            end
            WB: begin
                result_valid = 1'b1;
                state_nxt    = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // Instruction latch, result capture and working-register writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            sel_q    <= 1'b0;
            adr_q    <= '0;
            bsel_q   <= '0;
            imm_q    <= '0;
            r0       <= '0;
            r1       <= '0;
            result_q <= '0;
            wb_en_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        op_q     <= opcode;
                        sel_q    <= sel;
                        adr_q    <= adr;
                        bsel_q   <= bsel;
                        imm_q    <= imm;
                        result_q <= int_calc(opcode, r0, r1, rs_in, ro_in, imm);
                        wb_en_q  <= writes_reg(opcode);
                    end
                end
                WAIT_FP: begin
                    if (fp_done) begin
                        result_q <= fp_result;
                    end else if (fp_timeout) begin
                        result_q <= '0;
                        wb_en_q  <= 1'b0;
                    end
                end
                MEM_WAIT: result_q <= load_calc(op_q, rs_cur, mem_rdata, bsel_q);
                MEM_WR:   result_q <= '0;
                WB: begin
                    if (wb_en_q) begin
                        if (sel_q) r1 <= result_q;
                        else       r0 <= result_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_alu_sequencer.sv
// Testbench for fp_alu_sequencer: directed plan steps plus random instructions
// checked against an instruction-level reference model (register pair and
// memory image updated per instruction with plain arithmetic).
module tb_fp_alu_sequencer;

`ifdef FP_SEQ_TIMEOUT_EN
    localparam int TMO     = 8;
    localparam int DUT_TMO = 8;
`else
    localparam int TMO     = 1 << 30;
    localparam int DUT_TMO = 64;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  opcode = '0;
    logic        sel = 1'b0;
    logic [5:0]  adr = '0;
    logic [1:0]  bsel = '0;
    logic [31:0] imm = '0;
    logic        mem_we, mem_re;
    logic [5:0]  mem_adr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        fp_start, fp_op;
    logic [31:0] fp_a, fp_b;
    logic        fp_done;
    logic [31:0] fp_result;
    logic [31:0] result;
    logic        result_valid, busy, err;
    logic [31:0] r0_q, r1_q;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    logic [31:0] ref_r   [2];
    logic        ref_err = 1'b0;

    int          fp_delay = 0;
    logic [31:0] fp_res = '0;
    int          fp_left;
    bit          fp_armed;

    fp_alu_sequencer #(.FP_TIMEOUT(DUT_TMO)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .sel(sel), .adr(adr), .bsel(bsel), .imm(imm),
        .mem_we(mem_we), .mem_re(mem_re), .mem_adr(mem_adr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .fp_start(fp_start), .fp_op(fp_op), .fp_a(fp_a), .fp_b(fp_b),
        .fp_done(fp_done), .fp_result(fp_result),
        .result(result), .result_valid(result_valid), .busy(busy), .err(err),
        .r0_q(r0_q), .r1_q(r1_q)
    );

    always #5 clk = ~clk;

    // Memory model: read data registered one cycle after mem_re.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_adr];
        else        mem_rdata <= 32'hBAD0_BAD0;
        if (mem_we) mem[mem_adr] <= mem_wdata;
    end

    // FP unit model: fp_done lands on the fp_delay-th WAIT_FP cycle (0-based).
    always @(posedge clk) begin
        if (fp_start) begin
            fp_armed <= 1'b1;
            fp_left  <= fp_delay;
        end else if (fp_armed) begin
            if (fp_left == 0) fp_armed <= 1'b0;
            else              fp_left  <= fp_left - 1;
        end
    end
    assign fp_done   = fp_armed && (fp_left == 0);
    assign fp_result = fp_done ? fp_res : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic exec(input logic [3:0] op, input logic s, input logic [5:0] a,
                        input logic [1:0] b, input logic [31:0] im,
                        input int fpd, input logic [31:0] fpr);
        logic [31:0] rs, ro, a0, a1, exp_res, sdata, fpb_e, fa, fb, res_seen, wd_seen;
        logic [5:0]  wa_seen, ra_seen;
        logic        fo, fpop_e;
        bit          wr, is_st, is_ld, is_fp, to, done;
        int          sh, exp_lat, cyc, we_cnt, re_cnt, st_cnt, both, rdy_busy;
        rs = ref_r[s];  ro = ref_r[!s];  a0 = ref_r[0];  a1 = ref_r[1];
        sh = int'(ro % 32);
        exp_res = 0; sdata = 0; wr = 0; is_st = 0; is_ld = 0; is_fp = 0;
        fpb_e = a1; fpop_e = 0;
        case (op)
            4'h0: is_fp = 1;
            4'h1: begin is_fp = 1; fpb_e = a1 ^ 32'h8000_0000; end
            4'h2: begin is_fp = 1; fpop_e = 1; end
            4'h3: begin exp_res = a0 & a1; wr = 1; end
            4'h4: begin exp_res = a0 | a1; wr = 1; end
            4'h5: begin is_st = 1; sdata = (a0 < a1) ? 1 : 0; end
            4'h6: begin is_ld = 1; exp_res = ref_mem[a]; end
            4'h7: begin exp_res = rs + im; wr = 1; end
            4'h8: begin is_st = 1; sdata = (rs < im) ? 1 : 0; end
            4'h9: begin is_st = 1; sdata = (rs >> (8 * int'(b))) % 256; end
            4'hA: begin
                is_ld = 1; wr = 1;
                exp_res = (rs & ~(32'hFF << (8 * int'(b))))
                        | ((ref_mem[a] % 256) << (8 * int'(b)));
            end
            4'hB: begin is_ld = 1; wr = 1; exp_res = (rs - rs % 65536) + ref_mem[a] % 65536; end
            4'hC: begin is_st = 1; sdata = rs % 65536; end
            4'hD: begin exp_res = rs << sh; wr = 1; end
            4'hE: begin is_st = 1; sdata = rs; end
            default: begin
                exp_res = rs[31] ? ~((~rs) >> sh) : (rs >> sh); wr = 1;
            end
        endcase
        to = is_fp && (fpd >= TMO);
        if (is_fp) begin
            exp_res = to ? 32'h0 : fpr;
            wr = !to;
        end
        exp_lat = is_fp ? (to ? TMO + 2 : 3 + fpd) : is_ld ? 3 : is_st ? 2 : 1;

        fp_delay = fpd; fp_res = fpr;
        @(negedge clk);
        chk("ready_idle", {31'h0, instr_ready}, 32'h1);
        instr_valid = 1'b1; opcode = op; sel = s; adr = a; bsel = b; imm = im;
        cyc = 0; done = 0; we_cnt = 0; re_cnt = 0; st_cnt = 0; both = 0; rdy_busy = 0;
        res_seen = 'x; wd_seen = 'x; wa_seen = 'x; ra_seen = 'x; fa = 'x; fb = 'x; fo = 'x;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (instr_ready) rdy_busy++;
            if (mem_we && mem_re) both++;
            if (mem_we) begin we_cnt++; wd_seen = mem_wdata; wa_seen = mem_adr; end
            if (mem_re) begin re_cnt++; ra_seen = mem_adr; end
            if (fp_start) begin st_cnt++; fa = fp_a; fb = fp_b; fo = fp_op; end
            if (result_valid) begin
                done = 1; res_seen = result;
            end else begin
                instr_valid = 1'($urandom); opcode = 4'($urandom); sel = 1'($urandom);
                adr = 6'($urandom); bsel = 2'($urandom); imm = $urandom;
            end
        end
        instr_valid = 1'b0;

        if (wr) ref_r[s] = exp_res;
        if (is_st) ref_mem[a] = sdata;
        if (to) ref_err = 1'b1;

        chk("rv_seen", {31'h0, done}, 32'h1);
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("result", res_seen, exp_res);
        chk("ready_while_busy", 32'(rdy_busy), 32'h0);
        chk("strobe_excl", 32'(both), 32'h0);
        chk("we_count", 32'(we_cnt), {31'h0, is_st});
        chk("re_count", 32'(re_cnt), {31'h0, is_ld});
        chk("fp_start_count", 32'(st_cnt), {31'h0, is_fp});
        if (is_st) begin
            chk("wdata", wd_seen, sdata);
            chk("wadr", {26'h0, wa_seen}, {26'h0, a});
        end
        if (is_ld) chk("radr", {26'h0, ra_seen}, {26'h0, a});
        if (is_fp) begin
            chk("fp_a", fa, a0);
            chk("fp_b", fb, fpb_e);
            chk("fp_op", {31'h0, fo}, {31'h0, fpop_e});
        end
        @(negedge clk);
        chk("rv_one_cycle", {31'h0, result_valid}, 32'h0);
        chk("ready_after_wb", {31'h0, instr_ready}, 32'h1);
        chk("r0", r0_q, ref_r[0]);
        chk("r1", r1_q, ref_r[1]);
        chk("mem_word", mem[a], ref_mem[a]);
        chk("err", {31'h0, err}, {31'h0, ref_err});
    endtask

    task automatic set_reg(input logic s, input logic [31:0] v);
        exec(4'h7, s, 6'd0, 2'd0, v - ref_r[s], 0, 32'h0);
    endtask

    initial begin
        int rv_cnt, busy_cnt;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = $urandom;
            mem[i] <= ref_mem[i];
        end
        ref_r[0] = 0; ref_r[1] = 0;

        // Reset with junk on the inputs.
        instr_valid = 1'b1; opcode = 4'h7; imm = 32'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; instr_valid = 1'b0;
        chk("rst_ready", {31'h0, instr_ready}, 32'h1);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_rv", {31'h0, result_valid}, 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_r0", r0_q, 32'h0);
        chk("rst_r1", r1_q, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_strobes", {29'h0, mem_we, mem_re, fp_start}, 32'h0);

        // addi into r1: 5, then + 0xFFFFFFFE wraps to 3.
        exec(4'h7, 1'b1, 6'd0, 2'd0, 32'd5, 0, 32'h0);
        exec(4'h7, 1'b1, 6'd0, 2'd0, 32'hFFFF_FFFE, 0, 32'h0);
        chk("addi_r1_is_3", r1_q, 32'd3);

        // Store byte lane 2 of r0 to adr 9, load it back into r1 lane 0.
        set_reg(1'b0, 32'hAABB_CCDD);
        exec(4'h9, 1'b0, 6'd9, 2'd2, 32'h0, 0, 32'h0);
        chk("sb_mem9", mem[9], 32'h0000_00BB);
        exec(4'hA, 1'b1, 6'd9, 2'd0, 32'h0, 0, 32'h0);
        chk("lb_r1", r1_q, 32'h0000_00BB);

        // fsub 3.0 - 1.0 with a 4-cycle FP wait.
        set_reg(1'b0, 32'h4040_0000);
        set_reg(1'b1, 32'h3F80_0000);
        exec(4'h1, 1'b0, 6'd0, 2'd0, 32'h0, 4, 32'h4000_0000);
        chk("fsub_r0", r0_q, 32'h4000_0000);
        chk("fsub_r1_kept", r1_q, 32'h3F80_0000);

        // Arithmetic right shift then left shift by r1[4:0].
        set_reg(1'b0, 32'h8000_0010);
        set_reg(1'b1, 32'd4);
        exec(4'hF, 1'b0, 6'd0, 2'd0, 32'h0, 0, 32'h0);
        chk("sra_r0", r0_q, 32'hF800_0001);
        exec(4'hD, 1'b0, 6'd0, 2'd0, 32'h0, 0, 32'h0);
        chk("shl_r0", r0_q, 32'h8000_0010);

        // Random instructions against the reference model.
        for (int i = 0; i < 60; i++) begin
            exec(4'($urandom), 1'($urandom), 6'($urandom), 2'($urandom), $urandom,
                 int'($urandom_range(0, 5)), $urandom);
        end

        // Reset while in WAIT_FP: abandoned op, later fp_done ignored.
        set_reg(1'b0, 32'h1111_1111);
        set_reg(1'b1, 32'h2222_2222);
        fp_delay = 6; fp_res = 32'h7777_7777;
        @(negedge clk);
        instr_valid = 1'b1; opcode = 4'h0; sel = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("busy_in_wait", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ref_r[0] = 0; ref_r[1] = 0; ref_err = 1'b0;
        chk("mid_rst_ready", {31'h0, instr_ready}, 32'h1);
        chk("mid_rst_r0", r0_q, 32'h0);
        chk("mid_rst_r1", r1_q, 32'h0);
        chk("mid_rst_result", result, 32'h0);
        rv_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (result_valid) rv_cnt++;
            if (busy || fp_start || mem_we || mem_re) busy_cnt++;
        end
        chk("no_rv_after_rst", 32'(rv_cnt), 32'h0);
        chk("idle_after_late_done", 32'(busy_cnt), 32'h0);
        chk("late_done_r0", r0_q, 32'h0);
        exec(4'h4, 1'b1, 6'd0, 2'd0, 32'h0, 0, 32'h0);

`ifdef FP_SEQ_TIMEOUT_EN
        // FP unit never answers: abort, result 0, registers kept, err sticky.
        set_reg(1'b0, 32'h3F80_0000);
        set_reg(1'b1, 32'h4000_0000);
        exec(4'h0, 1'b0, 6'd0, 2'd0, 32'h0, 1000, 32'h1234_5678);
        chk("tmo_err", {31'h0, err}, 32'h1);
        chk("tmo_r0_kept", r0_q, 32'h3F80_0000);
        // fp_done on the last allowed WAIT_FP cycle wins over the abort.
        exec(4'h2, 1'b1, 6'd0, 2'd0, 32'h0, TMO - 1, 32'h4040_0000);
        chk("tmo_edge_r1", r1_q, 32'h4040_0000);
        chk("tmo_err_sticky", {31'h0, err}, 32'h1);
`else
        // Long FP wait without the timeout feature completes normally.
        exec(4'h2, 1'b1, 6'd0, 2'd0, 32'h0, 20, 32'h4040_0000);
        chk("no_tmo_err", {31'h0, err}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
